lcd_hex_line_writer: RTL and testbench

Parametrised successor to the RDID command/display sequencer. It latches a vector of NUM_BYTES bytes on a start strobe and converts each byte to two uppercase ASCII hex digits. It then streams one full LCD line, beginning with a DDRAM set-address command, into the transaction layer over its do_write_data/send_data_done handshake. Two instances, or one instance driven twice with line_sel, can fill both LCD lines.

---
 rtl/lcd_hex_line_writer.sv | 173 +++++++++++++++++
 tb/tb_lcd_hex_line_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_line_writer.sv
// Latches NUM_BYTES bytes on start and streams one LCD line (set-address command plus LINE_CHARS hex/space characters).
// Optional LCD_WRITER_RESTART_EN: start while busy re-latches and reissues the address command once the byte in flight completes.
module lcd_hex_line_writer #(
  parameter int          NUM_BYTES  = 3,
  parameter logic [7:0]  SEP_CHAR   = 8'h20,
  parameter int          LINE_CHARS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   line_sel,
  input  logic [8*NUM_BYTES-1:0] data_in,
  input  logic                   init_done,
  input  logic                   send_data_done,
  output logic                   do_write_data,
  output logic [7:0]             data_to_write,
  output logic                   is_command,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W    = $clog2(LINE_CHARS + 1);
  localparam int LAST_HEX = 3 * NUM_BYTES - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_ADDR,
    S_WAIT_ADDR,
    S_CHAR,
    S_WAIT_CHAR,
    S_FINISH
  } state_t;

  state_t                 state;
  logic [8*NUM_BYTES-1:0] data_q;
  logic                   sel_q;
  logic [IDX_W-1:0]       idx;
  logic                   restart;
  logic                   relatch;
  logic                   sel_next;
  logic [7:0]             char_sel;
  logic [7:0]             cur_byte;
  int                     pos;
  int                     byte_k;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] addr_cmd(input logic sel);
    return sel ? 8'hC0 : 8'h80;
  endfunction

  // Character at the current index: hi nibble, lo nibble, separator per byte; blanks after the last lo nibble.
  always_comb begin
    pos    = int'(idx);
    byte_k = pos / 3;
    if (byte_k > NUM_BYTES - 1) byte_k = NUM_BYTES - 1;
    cur_byte = 8'(data_q >> (8 * (NUM_BYTES - 1 - byte_k)));
    char_sel = 8'h20;
    if (pos <= LAST_HEX) begin
      case (pos % 3)
        0:       char_sel = hex_ascii(cur_byte[7:4]);
        1:       char_sel = hex_ascii(cur_byte[3:0]);
        default: char_sel = SEP_CHAR;
      endcase
    end
  end

`ifdef LCD_WRITER_RESTART_EN
  assign relatch  = start && (state != S_IDLE) && (state != S_FINISH);
`else
  assign relatch  = 1'b0;
  assign restart  = 1'b0;
`endif
  assign sel_next = relatch ? line_sel : sel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      data_q        <= '0;
      sel_q         <= 1'b0;
      idx           <= '0;
      do_write_data <= 1'b0;
      data_to_write <= 8'h00;
      is_command    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef LCD_WRITER_RESTART_EN
      restart       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            data_q <= data_in;
            sel_q  <= line_sel;
            busy   <= 1'b1;
            state  <= S_WAIT_INIT;
          end
        end
        S_WAIT_INIT: begin
          // Request goes out on this edge so that ADDR already shows it.
          if (init_done) begin
            do_write_data <= 1'b1;
            data_to_write <= addr_cmd(sel_next);
            is_command    <= 1'b1;
            state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!do_write_data) begin
            do_write_data <= 1'b1;
            data_to_write <= addr_cmd(sel_q);
            is_command    <= 1'b1;
          end
`ifdef LCD_WRITER_RESTART_EN
          restart <= 1'b0;
`endif
          state <= S_WAIT_ADDR;
        end
        S_WAIT_ADDR: begin
          if (send_data_done) begin
            do_write_data <= 1'b0;
            idx           <= '0;
            state         <= restart ? S_ADDR : S_CHAR;
          end
        end
        S_CHAR: begin
          if (restart) begin
            state <= S_ADDR;
          end else if (init_done) begin
            do_write_data <= 1'b1;
            data_to_write <= char_sel;
            is_command    <= 1'b0;
            state         <= S_WAIT_CHAR;
          end
        end
        S_WAIT_CHAR: begin
          if (send_data_done) begin
            do_write_data <= 1'b0;
            if (restart) begin
              state <= S_ADDR;
            end else if (idx == IDX_W'(LINE_CHARS - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_CHAR;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef LCD_WRITER_RESTART_EN
      // Placed after the case so a start in ADDR wins over that state's clear.
      if (relatch) begin
        data_q <= data_in;
        sel_q  <= line_sel;
        if (state != S_WAIT_INIT) restart <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lcd_hex_line_writer.sv
// Directed bench for lcd_hex_line_writer: scoreboard of expected transfers popped by a randomised-delay responder.
module tb_lcd_hex_line_writer;

  localparam int NB = 3;
  localparam int LC = 16;

  typedef struct packed {
    logic       cmd;
    logic [7:0] dat;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            line_sel;
  logic [8*NB-1:0] data_in;
  logic            init_done;
  logic            send_data_done;
  logic            do_write_data;
  logic [7:0]      data_to_write;
  logic            is_command;
  logic            busy;
  logic            done;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   hs_cnt  = 0;
  int   done_cnt = 0;
  int   max_dly = 0;

  lcd_hex_line_writer #(.NUM_BYTES(NB), .SEP_CHAR(8'h20), .LINE_CHARS(LC)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .line_sel       (line_sel),
    .data_in        (data_in),
    .init_done      (init_done),
    .send_data_done (send_data_done),
    .do_write_data  (do_write_data),
    .data_to_write  (data_to_write),
    .is_command     (is_command),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    if (3 * NB - 1 > LC) $fatal(1, "illegal configuration: 3*NUM_BYTES-1 exceeds LINE_CHARS");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference line built from a hex digit table.
  task automatic push_line(input logic [8*NB-1:0] d, input logic sel, input int n);
    string hexd;
    exp_t  line[$];
    logic [7:0] b;
    hexd = "0123456789ABCDEF";
    line.push_back({1'b1, (sel ? 8'hC0 : 8'h80)});
    for (int k = 0; k < NB; k++) begin
      b = d[8*(NB-1-k) +: 8];
      line.push_back({1'b0, hexd[int'(b[7:4])]});
      line.push_back({1'b0, hexd[int'(b[3:0])]});
      if (k < NB - 1) line.push_back({1'b0, 8'h20});
    end
    while (line.size() < LC + 1) line.push_back({1'b0, 8'h20});
    for (int i = 0; i < n; i++) exp_q.push_back(line[i]);
  endtask

  // Transaction-layer model: checks each request, holds it 1..max_dly+1 cycles, then pulses done.
  initial begin : responder
    exp_t cap;
    exp_t e;
    int   d;
    bit   abort;
    send_data_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset && do_write_data) begin
        hs_cnt++;
        cap = {is_command, data_to_write};
        chk("exp_avail", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("xfer", 32'(cap), 32'(e));
        end
        d = $urandom_range(0, max_dly);
        abort = 1'b0;
        for (int i = 0; i <= d && !abort; i++) begin
          @(posedge clk); #1;
          if (!reset) abort = 1'b1;
          else chk("hold", 32'({do_write_data, cap.cmd == is_command, cap.dat == data_to_write}), 32'h7);
        end
        if (!abort) begin
          send_data_done = 1'b1;
          @(posedge clk); #1;
          send_data_done = 1'b0;
          if (reset) chk("gap", 32'(do_write_data), 32'd0);
        end
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic pulse_start(input logic [8*NB-1:0] d, input logic sel);
    @(posedge clk); #1;
    data_in = d; line_sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic line_end(input string tag, input int base_done, input int hs0, input int hs_exp);
    repeat (4) @(posedge clk); #1;
    chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt - base_done), 32'd1);
    chk({tag, "_handshakes"}, 32'(hs_cnt - hs0), 32'(hs_exp));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && hs_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, 32'(hs_cnt >= target), 32'd1);
  endtask

  initial begin : main
    int base;
    int hs0;
    bit early;
    logic [8*NB-1:0] rd;
    reset = 1'b0; start = 1'b0; line_sel = 1'b0; data_in = '0; init_done = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 32'({do_write_data, data_to_write, is_command, busy, done}), 32'd0);
    @(negedge clk) reset = 1'b1;

    // 1: line 1, latency and content
    base = done_cnt; hs0 = hs_cnt;
    push_line(24'h202015, 1'b0, LC + 1);
    pulse_start(24'h202015, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_req_early", 32'(do_write_data), 32'd0);
    @(posedge clk); #1;
    chk("t1_latency", 32'(do_write_data), 32'd1);
    wait_done("t1_done", 400);
    line_end("t1", base, hs0, LC + 1);

    // 2: line 2 with 8/9/A/F digits; start during FINISH is ignored
    base = done_cnt; hs0 = hs_cnt;
    push_line(24'h9AF0C8, 1'b1, LC + 1);
    pulse_start(24'h9AF0C8, 1'b1);
    wait_done("t2_done", 400);
    data_in = 24'h111111; line_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t2_finish_start_busy", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    line_end("t2", base, hs0, LC + 1);

    // 3: random data and random done delays
    max_dly = 7;
    for (int n = 0; n < 2; n++) begin
      rd = 24'($urandom);
      base = done_cnt; hs0 = hs_cnt;
      push_line(rd, n[0], LC + 1);
      pulse_start(rd, n[0]);
      wait_done("t3_done", 600);
      line_end("t3", base, hs0, LC + 1);
    end

    // 4: init_done held low at start
    max_dly = 2;
    init_done = 1'b0;
    base = done_cnt; hs0 = hs_cnt;
    push_line(24'h5A0F3E, 1'b0, LC + 1);
    pulse_start(24'h5A0F3E, 1'b0);
    early = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (do_write_data) early = 1'b1;
    end
    chk("t4_no_req_before_init", 32'(early), 32'd0);
    chk("t4_busy_waiting", 32'(busy), 32'd1);
    init_done = 1'b1;
    @(posedge clk); #1;
    chk("t4_req_after_init", 32'({do_write_data, is_command, data_to_write}), 32'h3_80);
    wait_done("t4_done", 400);
    line_end("t4", base, hs0, LC + 1);

    // 5: reset at the 5th character, then a fresh line of zeros
    max_dly = 1;
    hs0 = hs_cnt;
    push_line(24'h3C7E11, 1'b0, LC + 1);
    pulse_start(24'h3C7E11, 1'b0);
    wait_hs("t5_reach_char5", hs0 + 6, 200);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("t5_async_clear", 32'({do_write_data, data_to_write, is_command, busy, done}), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    base = done_cnt; hs0 = hs_cnt;
    push_line(24'h000000, 1'b0, LC + 1);
    pulse_start(24'h000000, 1'b0);
    wait_done("t5_done", 400);
    line_end("t5", base, hs0, LC + 1);

    // 6: second start while the 3rd character is in flight
    max_dly = 2;
    base = done_cnt; hs0 = hs_cnt;
`ifdef LCD_WRITER_RESTART_EN
    push_line(24'h123456, 1'b0, 4);
`else
    push_line(24'h123456, 1'b0, LC + 1);
`endif
    pulse_start(24'h123456, 1'b0);
    wait_hs("t6_reach_char3", hs0 + 4, 200);
`ifdef LCD_WRITER_RESTART_EN
    push_line(24'hABCDEF, 1'b1, LC + 1);
`endif
    pulse_start(24'hABCDEF, 1'b1);
    wait_done("t6_done", 600);
`ifdef LCD_WRITER_RESTART_EN
    line_end("t6", base, hs0, LC + 5);
`else
    line_end("t6", base, hs0, LC + 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
